// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and prefetch FIFO feeding decode; optional FETCH_BYPASS_EN zero-latency path
module fetch_queue #(
  parameter int DataSize = 32,
  parameter int PCsize = 6,
  parameter int Depth = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [PCsize-1:0]         imem_addr,
  input  logic [DataSize-1:0]       imem_data,
  input  logic                      redirect,
  input  logic [PCsize-1:0]         redirect_pc,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [DataSize-1:0]       instr,
  output logic [PCsize-1:0]         instr_pc,
  output logic [$clog2(Depth):0]    count
);
  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] FULL = (AW+1)'(Depth);
  logic [PCsize-1:0] pc;
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic [DataSize-1:0] mem_d [Depth];
  logic [PCsize-1:0] mem_pc [Depth];
  logic q_valid, pop, push, st, bp;
  assign q_valid = cnt != '0;
  assign pop = q_valid & instr_ready;
  assign push = !redirect & (cnt < FULL | pop);
`ifdef FETCH_BYPASS_EN
  assign bp = !q_valid & !redirect & instr_ready;
`else
  assign bp = 1'b0;
`endif
  assign st = push & !bp;
  assign imem_addr = pc;
  assign count = cnt;
  // head of queue, or the live fetch word when bypassing an empty queue
  always_comb begin
    instr_valid = q_valid | bp;
    instr = bp ? imem_data : q_valid ? mem_d[rd] : '0;
    instr_pc = bp ? pc : q_valid ? mem_pc[rd] : '0;
  end
  // fetch PC, pointers and occupancy; redirect flushes and reloads the PC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else if (redirect) begin
      pc <= redirect_pc;
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      pc <= push ? pc + PCsize'(1) : pc;
      rd <= pop ? rd + AW'(1) : rd;
      wr <= st ? wr + AW'(1) : wr;
      cnt <= (st & !pop) ? cnt + (AW+1)'(1) : (!st & pop) ? cnt - (AW+1)'(1) : cnt;
    end
  end
  // storage array; contents are masked by count so no reset is needed
  always_ff @(posedge clk) begin
    if (st) begin
      mem_d[wr] <= imem_data;
      mem_pc[wr] <= pc;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a queue-based model
module tb_fetch_queue;
  logic clk = 0, rst = 0;
  logic [5:0] imem_addr, redirect_pc = 0, instr_pc;
  logic [31:0] imem_data, instr;
  logic redirect = 0, instr_valid, instr_ready = 0;
  logic [2:0] count;
  logic [31:0] rom [64];
  logic [37:0] q [$];
  logic [5:0] mpc;
  int passed = 0, total = 0;

  fetch_queue dut (.clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .count(count));

  assign imem_data = rom[imem_addr];
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic model_bp();
`ifdef FETCH_BYPASS_EN
    return q.size() == 0 && !redirect && instr_ready;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs();
    logic bp;
    logic [37:0] h;
    bp = model_bp();
    h = bp ? {rom[mpc], mpc} : (q.size() != 0) ? q[0] : 38'd0;
    chk("valid", instr_valid, bp || q.size() != 0);
    chk("instr", instr, h[37:6]);
    chk("instr_pc", instr_pc, h[5:0]);
    chk("count", count, q.size());
    chk("imem_addr", imem_addr, mpc);
  endtask

  task automatic cycle(input logic r, input logic rd_i, input logic [5:0] rp);
    logic bp, pop, full;
    instr_ready = r; redirect = rd_i; redirect_pc = rp;
    #1 check_outputs();
    bp = model_bp();
    if (rd_i) begin
      q.delete();
      mpc = rp;
    end else begin
      full = q.size() >= 4;
      pop = q.size() != 0 && r;
      if (pop) void'(q.pop_front());
      if (bp) mpc++;
      else if (!full || pop) begin
        q.push_back({rom[mpc], mpc});
        mpc++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_count", count, 0);
    chk("rst_addr", imem_addr, 0);
    q.delete();
    mpc = 0;
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h2000_0000 + i;
    mpc = 0;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, 0, 0);
    chk("stream_pc", instr_pc, 6'd9);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(0, 0, 0);
    chk("fill_count", count, 3'd4);
    chk("fill_addr", imem_addr, 6'd4);
    cycle(1, 0, 0);
    chk("fullpop_count", count, 3'd4);
    chk("fullpop_addr", imem_addr, 6'd5);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    cycle(1, 1, 6'h20);
    chk("redir_count", count, 0);
    chk("redir_addr", imem_addr, 6'h20);
    cycle(1, 0, 0);
    chk("redir_pc", instr_pc, 6'h20);
    cycle(1, 1, 6'd60);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    chk("midfill_count", count, 3'd3);
    #2 do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 6'($urandom));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
